// File: rtl/sipo_frame_rx_if.sv
// Parallel/serial signal bundle for sipo_frame_rx.
// Defining SIPO_RX_PARITY_EN adds parity_err.
interface sipo_frame_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_bit;
  logic                  in_bit_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_err;
  logic                  overrun;
`ifdef SIPO_RX_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output in_bit, in_bit_valid, out_ready,
`ifdef SIPO_RX_PARITY_EN
    input  parity_err,
`endif
    input  out_data, out_valid, frame_err, overrun
  );

  modport slave (
    input  in_bit, in_bit_valid, out_ready,
`ifdef SIPO_RX_PARITY_EN
    output parity_err,
`endif
    output out_data, out_valid, frame_err, overrun
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, MSB-first data, optional even parity, stop bit.
// Optional feature: SIPO_RX_PARITY_EN enables the parity bit and parity_err.
module sipo_frame_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  sipo_frame_rx_if.slave  bus
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
`ifdef SIPO_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  par_acc;
  logic                  par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      par_acc        <= 1'b0;
      par_bad        <= 1'b0;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
      // Acceptance clears valid; a load on the same edge below takes priority.
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;

      if (bus.in_bit_valid) begin
        unique case (state)
          IDLE: begin
            if (!bus.in_bit) begin
              state   <= DATA;
              cnt     <= '0;
              par_acc <= 1'b0;
              par_bad <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= {shreg[DATA_WIDTH-2:0], bus.in_bit};
            par_acc <= par_acc ^ bus.in_bit;
            cnt     <= cnt + 1'b1;
            if (cnt == CW'(DATA_WIDTH - 1)) begin
`ifdef SIPO_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SIPO_RX_PARITY_EN
          PARITY: begin
            par_bad <= par_acc ^ bus.in_bit;
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
`ifdef SIPO_RX_PARITY_EN
            bus.parity_err <= par_bad;
`endif
            if (!bus.in_bit) begin
              bus.frame_err <= 1'b1;
            end else if (!par_bad) begin
              if (!bus.out_valid || bus.out_ready) begin
                bus.out_data  <= shreg;
                bus.out_valid <= 1'b1;
              end else begin
                bus.overrun <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx with a frame-level queue model checked every cycle.
module tb_sipo_frame_rx;
  localparam int W = 8;
`ifdef SIPO_RX_PARITY_EN
  localparam int FL = W + 3;
`else
  localparam int FL = W + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sipo_frame_rx_if #(.DATA_WIDTH(W)) bus ();

  sipo_frame_rx #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Frame-level model: collect the qualified bits of one frame, then judge it whole.
  bit           q[$];
  logic         m_valid, m_ferr, m_ovr, m_perr;
  logic [W-1:0] m_data;
  int           n_acc = 0;
  logic [W-1:0] last_acc = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_valid = 1'b0; m_data = '0;
      m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      logic [W-1:0] word;
      logic ok;
      m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        n_acc++;
        last_acc = bus.out_data;
      end
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (bus.in_bit_valid) begin
        if (q.size() != 0 || bus.in_bit == 1'b0) q.push_back(bus.in_bit);
        if (q.size() == FL) begin
          word = '0;
          for (int i = 1; i <= W; i++) word[W-i] = q[i];
`ifdef SIPO_RX_PARITY_EN
          ok = ((^word) == q[W+1]);
`else
          ok = 1'b1;
`endif
          if (!q[FL-1]) m_ferr = 1'b1;
          if (!ok) m_perr = 1'b1;
          if (q[FL-1] && ok) begin
            if (!m_valid) begin m_valid = 1'b1; m_data = word; end
            else m_ovr = 1'b1;
          end
          q.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  int n_ferr = 0, n_ovr = 0, n_perr = 0;

  task automatic compare_loop();
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data",  32'(bus.out_data),  32'(m_data));
        chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
        chk("overrun",   32'(bus.overrun),   32'(m_ovr));
        if (bus.frame_err) n_ferr++;
        if (bus.overrun)   n_ovr++;
`ifdef SIPO_RX_PARITY_EN
        chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
        if (bus.parity_err) n_perr++;
`endif
      end
    end
  endtask

  task automatic put(input logic b);
    @(negedge clk);
    bus.in_bit = b;
    bus.in_bit_valid = 1'b1;
  endtask

  // Gaps drive in_bit=0 so a stall that leaked through would look like data/start.
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_bit_valid = 1'b0;
      bus.in_bit = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input int stall, input logic stop,
                            input logic par_good, input logic ready_at_stop);
    put(1'b0); gap(stall);
    for (int i = W - 1; i >= 0; i--) begin
      put(d[i]); gap(stall);
    end
`ifdef SIPO_RX_PARITY_EN
    put((^d) ^ ~par_good); gap(stall);
`endif
    put(stop);
    if (ready_at_stop) bus.out_ready = 1'b1;
  endtask

  int b_acc, b_ferr, b_ovr, b_perr;
  task automatic base();
    b_acc = n_acc; b_ferr = n_ferr; b_ovr = n_ovr; b_perr = n_perr;
  endtask

  initial begin
    bus.in_bit = 1'b1; bus.in_bit_valid = 1'b0; bus.out_ready = 1'b1;
    fork compare_loop(); join_none

    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gap(2);

    // Basic frame 0xA5
    base();
    send_frame(8'hA5, 0, 1'b1, 1'b1, 1'b0); gap(3);
    chk("basic_acc_cnt", 32'(n_acc - b_acc), 32'd1);
    chk("basic_data",    32'(last_acc), 32'hA5);
    chk("basic_ferr",    32'(n_ferr - b_ferr), 32'd0);

    // Same frame with 3-cycle stalls between every bit
    base();
    send_frame(8'hA5, 3, 1'b1, 1'b1, 1'b0); gap(3);
    chk("stall_acc_cnt", 32'(n_acc - b_acc), 32'd1);
    chk("stall_data",    32'(last_acc), 32'hA5);

    // Bad stop, then a good frame right behind it
    base();
    send_frame(8'h3C, 0, 1'b0, 1'b1, 1'b0); gap(2);
    chk("badstop_ferr", 32'(n_ferr - b_ferr), 32'd1);
    chk("badstop_acc",  32'(n_acc - b_acc), 32'd0);
    send_frame(8'h81, 0, 1'b1, 1'b1, 1'b0); gap(3);
    chk("after_bad_data", 32'(last_acc), 32'h81);

    // Backpressure and overrun with back-to-back frames
    base();
    bus.out_ready = 1'b0;
    send_frame(8'h11, 0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 0, 1'b1, 1'b1, 1'b0); gap(2);
    chk("bp_hold_data",  32'(bus.out_data), 32'h11);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_overrun",    32'(n_ovr - b_ovr), 32'd1);
    @(negedge clk); bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    chk("bp_acc_data", 32'(last_acc), 32'h11);

    base();
    bus.out_ready = 1'b0;
    send_frame(8'h44, 0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 0, 1'b1, 1'b1, 1'b1); gap(3);
    chk("ready_at_stop_ovr",  32'(n_ovr - b_ovr), 32'd0);
    chk("ready_at_stop_data", 32'(last_acc), 32'h55);
    chk("ready_at_stop_acc",  32'(n_acc - b_acc), 32'd2);

    // Reset in the middle of a frame while a word is pending
    bus.out_ready = 1'b0;
    send_frame(8'h66, 0, 1'b1, 1'b1, 1'b0); gap(2);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    put(1'b0); put(1'b1); put(1'b0); put(1'b1); put(1'b1);
    @(negedge clk);
    bus.in_bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_data",  32'(bus.out_data),  32'd0);
    @(negedge clk); rst = 1'b0;
    bus.out_ready = 1'b1;
    base();
    gap(3);
    send_frame(8'hF0, 0, 1'b1, 1'b1, 1'b0); gap(3);
    chk("post_rst_data", 32'(last_acc), 32'hF0);
    chk("post_rst_ferr", 32'(n_ferr - b_ferr), 32'd0);
    chk("post_rst_ovr",  32'(n_ovr - b_ovr), 32'd0);

`ifdef SIPO_RX_PARITY_EN
    base();
    send_frame(8'h07, 0, 1'b1, 1'b1, 1'b0); gap(3);
    chk("par_good_data", 32'(last_acc), 32'h07);
    chk("par_good_perr", 32'(n_perr - b_perr), 32'd0);
    base();
    send_frame(8'h07, 0, 1'b1, 1'b0, 1'b0); gap(3);
    chk("par_bad_perr", 32'(n_perr - b_perr), 32'd1);
    chk("par_bad_acc",  32'(n_acc - b_acc), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial frame receiver: the receive end of a PISO-driven serial link.
- Detects a start bit, deserializes DATA_WIDTH bits MSB-first into a shift register, checks the stop bit, and presents the word on a valid/ready parallel interface.
- Sits between a PISO transmitter (or an external serial pin) and a parallel consumer; one bit is consumed per qualified clock.

Parameters:
- DATA_WIDTH, 8, payload bits per frame. Legal values 2..32.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_bit  input  1  serial line value; idle level is 1
- in_bit_valid  input  1  strobe; in_bit is sampled only on cycles where this is 1
- out_data  output  DATA_WIDTH  received word; stable while out_valid=1
- out_valid  output  1  word available
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  one-cycle pulse: a good frame completed while the previous word was still unaccepted

Behaviour:
- Reset values (async on rst=1):
  - FSM=IDLE, shift register=0, bit counter=0.
  - out_data=0, out_valid=0, frame_err=0, overrun=0.
- Reset mid-frame: the partial frame is discarded; no pulse is generated after reset is released.
- Frame format on qualified samples: start(0), D[DATA_WIDTH-1] … D[0] (MSB first), [parity if enabled], stop(1).
- FSM states: IDLE, DATA, PARITY (only with the optional feature), STOP.
  - IDLE: on in_bit_valid && in_bit==0, go to DATA with bit counter=0. A sampled 1 stays in IDLE.
  - DATA: on each in_bit_valid, shift in_bit into the LSB (shreg <= {shreg[W-2:0], in_bit}) and increment the counter. After the DATA_WIDTH-th bit, go to STOP (or PARITY).
  - STOP, with in_bit_valid:
    - in_bit==1: the frame is good; go to IDLE.
    - in_bit==0: frame_err=1 for the next cycle, the word is dropped, and the FSM returns to IDLE. A stop-bit 0 is never treated as a new start bit.
- in_bit_valid=0 in any state: the FSM, counter and shift register hold. Stalls of any length are legal.
- Output register update, on the good-stop-bit cycle:
  - If out_valid==0, or out_valid && out_ready in the same cycle: out_data <= shreg and out_valid <= 1, visible the cycle after the stop sample. Latency from the stop sample to out_valid is 1 clk.
  - Else (previous word still pending): the new word is dropped, out_data is unchanged, and overrun=1 for one cycle.
- Handshake:
  - out_valid clears the cycle after out_valid && out_ready unless a new word loads in that same edge.
  - out_valid never drops without acceptance.
  - out_data does not change while out_valid=1 and out_ready=0.
- Back-to-back frames: a start bit sampled on the qualified sample immediately after the stop bit is accepted. Zero idle bits are required.
- Bit counter width: $clog2(DATA_WIDTH)+1; it never wraps within a frame.

Optional Feature:
- Macro: SIPO_RX_PARITY_EN
- Defined:
  - An even-parity bit follows D[0]. PARITY state samples it and compares it against the XOR of the received data bits.
  - Adds an output parity_err (1 bit, reset 0): a one-cycle pulse the cycle after the stop sample of a frame whose parity mismatched.
  - A parity-failed frame is dropped: out_valid is not set and overrun is not pulsed.
  - Stop-bit checking is unchanged; if both the stop bit and parity fail, both error pulses fire.
- Not defined: there is no PARITY state and no parity_err port; the frame is start + data + stop.

Test Plan:
- Basic frame (DATA_WIDTH=8, out_ready=1): rst pulse, then valid samples 0,1,0,1,0,0,1,0,1,1 → out_valid=1 for exactly one cycle, 1 clk after the stop sample, out_data=8'hA5; frame_err=0.
- Stalls: the same 0xA5 frame with in_bit_valid deasserted for 3 cycles between every bit → identical result (8'hA5, one out_valid); no state advance during stalls.
- Bad stop: start, data 8'h3C, stop sampled as 0 → frame_err pulses once; out_valid stays 0. A following good frame 8'h81 → out_data=8'h81.
- Backpressure/overrun: out_ready=0, frames 8'h11 then 8'h22 back-to-back → out_data=8'h11 held, overrun pulses once at the second stop. Raise out_ready → 8'h11 accepted, out_valid then 0. With out_ready=1 on the completion cycle of 8'h22 → 8'h22 loaded, no overrun.
- Reset mid-frame: assert rst after 4 data bits → all outputs 0 immediately (async). Release rst and send frame 8'hF0 → out_data=8'hF0; no error pulses.
- Parity (SIPO_RX_PARITY_EN): frame 8'h07 with parity bit 1 → accepted. Same frame with parity bit 0 → parity_err pulses, out_valid stays 0.
